// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } arb_state_e;

  localparam logic Port0 = 1'b0;
  localparam logic Port1 = 1'b1;

  localparam int unsigned DefaultWordDepth = 64;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between the two requesters.
// DMEM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef DMEM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic any_req,
  output logic winner
);

  always_comb begin
    any_req = req0 | req1;
`ifdef DMEM_ARB_RR_EN
    // On a tie the port not granted last goes first.
    if (req0 && req1) begin
      winner = ~last_grant;
    end else begin
      winner = req1 ? Port1 : Port0;
    end
`else
    winner = req0 ? Port0 : Port1;
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: one access per IDLE/ACCESS/RESP round.
// DMEM_ARB_RR_EN enables round-robin arbitration (default: fixed priority).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WORD_DEPTH = DefaultWordDepth
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state_q, state_d;
  logic win_q, we_q, err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, rdata_q;

  logic any_req, winner, sel_we, sel_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
  logic last_q;
`endif

  dmem_arb_pick u_pick (
    .req0      (req0),
    .req1      (req1),
`ifdef DMEM_ARB_RR_EN
    .last_grant(last_q),
`endif
    .any_req   (any_req),
    .winner    (winner)
  );

  always_comb begin
    sel_we    = (winner == Port1) ? we1 : we0;
    sel_addr  = (winner == Port1) ? addr1 : addr0;
    sel_wdata = (winner == Port1) ? wdata1 : wdata0;
    sel_err   = (sel_addr[1:0] != 2'b00) ||
                (64'(sel_addr[ADDR_W-1:2]) >= 64'(WORD_DEPTH));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_req) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_read  = (state_q == StAccess) && !we_q && !err_q;
    mem_write = (state_q == StAccess) && we_q && !err_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    ack0      = (state_q == StResp) && (win_q == Port0);
    ack1      = (state_q == StResp) && (win_q == Port1);
    err0      = ack0 && err_q;
    err1      = ack1 && err_q;
    rdata     = rdata_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      win_q       <= Port0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
`ifdef DMEM_ARB_RR_EN
      last_q      <= Port1;
`endif
    end else begin
      state_q <= state_d;
      // The memory-side address/data registers double as the held request fields.
      if (state_q == StIdle && any_req) begin
        win_q       <= winner;
        we_q        <= sel_we;
        err_q       <= sel_err;
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
`ifdef DMEM_ARB_RR_EN
        last_q      <= winner;
`endif
      end
      if (state_q == StAccess) begin
        rdata_q <= (!we_q && !err_q) ? mem_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned WD = 64;

  logic clock = 1'b0;
  logic reset;
  logic req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic ack0, ack1, err0, err1;
  logic [DW-1:0] rdata;
  logic mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // External memory and its reference copy.
  logic [DW-1:0] mem [WD];
  logic [DW-1:0] ref_mem [WD];

  // Pending request per port, held stable until acked.
  bit            p_req   [2];
  logic          p_we    [2];
  logic [AW-1:0] p_addr  [2];
  logic [DW-1:0] p_wdata [2];
  int            ref_last;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .WORD_DEPTH(WD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .ack0     (ack0),
    .ack1     (ack1),
    .err0     (err0),
    .err1     (err1),
    .rdata    (rdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clock) begin
    if (mem_write) mem[mem_addr[7:2]] = mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic drive();
    req0 = p_req[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wdata[0];
    req1 = p_req[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wdata[1];
  endtask

  task automatic set_req(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    p_req[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wdata[p] = d;
  endtask

  task automatic new_req(input int p);
    int r;
    logic [AW-1:0] a;
    r = $urandom_range(0, 9);
    if (r < 8)       a = AW'($urandom_range(0, WD - 1)) << 2;
    else if (r == 8) a = (AW'($urandom_range(0, WD - 1)) << 2) | AW'($urandom_range(1, 3));
    else             a = AW'($urandom_range(WD, 4 * WD)) << 2;
    set_req(p, 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  function automatic int exp_winner();
    if (p_req[0] && p_req[1]) begin
`ifdef DMEM_ARB_RR_EN
      return 1 - ref_last;
`else
      return 0;
`endif
    end
    return p_req[0] ? 0 : 1;
  endfunction

  function automatic bit is_err(input logic [AW-1:0] a);
    return (a % 4 != 0) || ((a / 4) >= WD);
  endfunction

  // Starts in IDLE with requests pending; ends one cycle into the following IDLE.
  task automatic run_txn(input string tag, input bit keep, output int w_obs);
    int w;
    bit e;
    logic [AW-1:0] a;
    logic [DW-1:0] exp_rd;
    drive();
    w = exp_winner();
    a = p_addr[w];
    e = is_err(a);
    @(posedge clock); #1;
    check_eq({tag, "/acc_rd"}, 64'(mem_read), 64'(!e && !p_we[w]));
    check_eq({tag, "/acc_wr"}, 64'(mem_write), 64'(!e && p_we[w]));
    check_eq({tag, "/acc_ack"}, 64'({ack1, ack0}), 64'(0));
    if (!e) begin
      check_eq({tag, "/acc_addr"}, 64'(mem_addr), 64'(a));
      if (p_we[w]) check_eq({tag, "/acc_wdata"}, 64'(mem_wdata), 64'(p_wdata[w]));
    end
    exp_rd = (!e && !p_we[w]) ? ref_mem[a[7:2]] : '0;
    if (!e && p_we[w]) ref_mem[a[7:2]] = p_wdata[w];
    @(posedge clock); #1;
    w_obs = ack1 ? 1 : 0;
    check_eq({tag, "/resp_ack"}, 64'({ack1, ack0}), (w == 0) ? 64'd1 : 64'd2);
    check_eq({tag, "/resp_err"}, 64'({err1, err0}), e ? ((w == 0) ? 64'd1 : 64'd2) : 64'd0);
    check_eq({tag, "/resp_rdata"}, 64'(rdata), 64'(exp_rd));
    check_eq({tag, "/resp_strobe"}, 64'({mem_read, mem_write}), 64'(0));
    ref_last = w;
    if (!keep) p_req[w] = 1'b0;
    drive();
    @(posedge clock); #1;
    check_eq({tag, "/idle_ack"}, 64'({ack1, ack0}), 64'(0));
    check_eq({tag, "/idle_rdata"}, 64'(rdata), 64'(exp_rd));
  endtask

  int w_obs;
  int exp_seq;
  logic [DW-1:0] v;

  initial begin
    for (int i = 0; i < int'(WD); i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    for (int p = 0; p < 2; p++) set_req(p, 1'b0, '0, '0);
    p_req[0] = 1'b0; p_req[1] = 1'b0;
    drive();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_eq("reset/ack_err", 64'({ack1, ack0, err1, err0}), 64'(0));
    check_eq("reset/strobe", 64'({mem_read, mem_write}), 64'(0));
    check_eq("reset/rdata", 64'(rdata), 64'(0));
    check_eq("reset/mem_addr", 64'(mem_addr), 64'(0));
    check_eq("reset/mem_wdata", 64'(mem_wdata), 64'(0));
    reset = 1'b0;
    ref_last = 1;

    // Both ports held continuously.
    set_req(0, 1'b0, 32'h10, '0);
    set_req(1, 1'b0, 32'h14, '0);
    for (int i = 0; i < 4; i++) begin
      run_txn("contend", 1'b1, w_obs);
`ifdef DMEM_ARB_RR_EN
      exp_seq = i % 2;
`else
      exp_seq = 0;
`endif
      check_eq("contend/order", 64'(w_obs), 64'(exp_seq));
    end
    p_req[0] = 1'b0;
    while (p_req[0] || p_req[1]) run_txn("drain", 1'b0, w_obs);

    mem[3] = 32'hDEADBEEF;
    ref_mem[3] = 32'hDEADBEEF;
    set_req(0, 1'b0, 32'h0C, '0);
    run_txn("load", 1'b0, w_obs);
    check_eq("load/rdata", 64'(rdata), 64'h0000_0000_DEAD_BEEF);

    set_req(1, 1'b1, 32'h08, 32'h12345678);
    run_txn("store", 1'b0, w_obs);
    set_req(0, 1'b0, 32'h08, '0);
    run_txn("st_ld", 1'b0, w_obs);
    check_eq("st_ld/rdata", 64'(rdata), 64'h0000_0000_1234_5678);

    set_req(0, 1'b0, 32'h102, '0);
    run_txn("err_misalign", 1'b0, w_obs);
    set_req(0, 1'b0, 32'h100, '0);
    run_txn("err_range", 1'b0, w_obs);

    for (int i = 0; i < 60; i++) begin
      for (int p = 0; p < 2; p++) if (!p_req[p] && $urandom_range(0, 1) == 1) new_req(p);
      if (!p_req[0] && !p_req[1]) new_req(int'($urandom_range(0, 1)));
      run_txn("rand", 1'b0, w_obs);
    end
    while (p_req[0] || p_req[1]) run_txn("drain", 1'b0, w_obs);

    // Reset in ACCESS with a store pending.
    set_req(1, 1'b1, 32'h20, 32'hCAFEF00D);
    drive();
    @(posedge clock); #1;
    check_eq("rst_acc/wr", 64'(mem_write), 64'(1));
    reset = 1'b1;
    // The write strobe was high at this edge, so memory accepts the word.
    ref_mem[8] = 32'hCAFEF00D;
    @(posedge clock); #1;
    check_eq("rst_acc/strobe", 64'({mem_read, mem_write}), 64'(0));
    check_eq("rst_acc/ack", 64'({ack1, ack0}), 64'(0));
    check_eq("rst_acc/rdata", 64'(rdata), 64'(0));
    check_eq("rst_acc/mem_addr", 64'(mem_addr), 64'(0));
    p_req[1] = 1'b0;
    drive();
    @(posedge clock); #1;
    check_eq("rst_hold/ack", 64'({ack1, ack0}), 64'(0));
    reset = 1'b0;
    ref_last = 1;
    set_req(0, 1'b0, 32'h20, '0);
    set_req(1, 1'b0, 32'h24, '0);
    run_txn("post_rst", 1'b0, w_obs);
    check_eq("post_rst/winner", 64'(w_obs), 64'(0));
    while (p_req[0] || p_req[1]) run_txn("drain", 1'b0, w_obs);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width of ports and memory side.
REQ-002 Parameter: DATA_W, 32, data word width.
REQ-003 Parameter: WORD_DEPTH, 64, number of memory words; accesses at word index >= WORD_DEPTH are out of range.
REQ-004 Port: clock  in  1  single clock; all state updates on the rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: req0, req1  in  1 each  access request; held high with stable fields until ack.
REQ-007 Port: we0, we1  in  1 each  1 = store, 0 = load.
REQ-008 Port: addr0, addr1  in  ADDR_W each  byte address.
REQ-009 Port: wdata0, wdata1  in  DATA_W each  store data.
REQ-010 Port: ack0, ack1  out  1 each  one-cycle completion pulse to the granted requester.
REQ-011 Port: err0, err1  out  1 each  valid only with ack; 1 = access rejected.
REQ-012 Port: rdata  out  DATA_W  load result, shared; valid with ack.
REQ-013 Port: mem_read, mem_write  out  1 each  memory strobes.
REQ-014 Port: mem_addr, mem_wdata  out  ADDR_W / DATA_W  memory address and store data.
REQ-015 Port: mem_rdata  in  DATA_W  combinational read data from memory.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; IDLE -> ACCESS when any req is high at the edge; ACCESS -> RESP unconditionally; RESP -> IDLE unconditionally.
REQ-017 In IDLE, the winner, its we/addr/wdata and the error flag are registered at the edge that leaves IDLE.
REQ-018 In ACCESS, mem_read = !we, mem_write = we, mem_addr and mem_wdata driven from registered values, for exactly one cycle.
REQ-019 At the ACCESS -> RESP edge, rdata captures mem_rdata for loads and is cleared to 0 for stores.
REQ-020 In RESP, exactly the winner's ack is high for one cycle; rdata holds until the next RESP.
REQ-021 Latency: req sampled at edge k -> strobes during cycle k..k+1 -> ack during k+1..k+2; one access per 3 cycles maximum.
REQ-022 Error when addr[1:0] != 0 or addr[ADDR_W-1:2] >= WORD_DEPTH: ACCESS issues no strobes, RESP asserts ack and err, rdata = 0.
REQ-023 Outside ACCESS, mem_read = mem_write = 0; mem_addr and mem_wdata hold their last values.
REQ-024 req dropped before ack is a protocol violation; the access still completes and ack still pulses.
REQ-025 Requests arriving in ACCESS or RESP wait; they are arbitrated only in IDLE.
REQ-026 A requester holding req after its ack is treated as a new request at the next IDLE edge.

Reset
REQ-027 reset high at an edge forces IDLE, all ack/err = 0, strobes = 0, rdata = 0, mem_addr = mem_wdata = 0, and the priority pointer so port 0 wins the next tie.
REQ-028 reset during ACCESS or RESP aborts the operation: strobes drop and no ack is issued for it; reset dominates any req.

Configuration
REQ-029 With DMEM_ARB_RR_EN defined: round-robin; the port not granted last wins a simultaneous req0 and req1; the pointer updates on every grant.
REQ-030 Without DMEM_ARB_RR_EN: fixed priority; port 0 always wins simultaneous requests; no pointer state exists.

Structure
REQ-031 Package dmem_arb_pkg holds the FSM state enum (IDLE/ACCESS/RESP), port-index constants and the default WORD_DEPTH.
REQ-032 One sub-module, dmem_arb_pick: combinational winner selection from req0, req1 and the pointer, swapped by the macro.
REQ-033 All FSM, registers and strobe generation live in dmem_arbiter; the memory array is external.

Verification
REQ-034 Load: memory word 3 = 0xDEADBEEF; req0, we0=0, addr0=0x0C -> mem_read one cycle with mem_addr=0x0C; ack0 two cycles after the sample edge; rdata=0xDEADBEEF; err0=0.
REQ-035 Store then load: req1, we1=1, addr1=0x08, wdata1=0x12345678 -> mem_write one cycle; ack1; a following port 0 load of 0x08 returns 0x12345678.
REQ-036 Contention: req0 and req1 held continuously -> RR build grants 0,1,0,1; fixed build grants 0,0,0 and port 1 never acks.
REQ-037 Errors: addr0=0x102 (misaligned), then addr0=0x100 (index 64) -> no strobes; ack0 and err0 both high; rdata=0.
REQ-038 Reset in ACCESS with a store pending: reset high one cycle -> mem_write low the next cycle, no ack; next request after reset is served normally, and in the RR build port 0 wins the first tie.
